// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - length-bounded unsigned multiply-accumulate with ready/valid handshakes
module mac_accumulator #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] counter;
  logic [2*DATA_WIDTH-1:0] product;
  logic [ACC_WIDTH:0]     sum;
  logic                   transfer;

  assign product  = a * b;
  // One spare bit on top of the accumulator catches the carry for the sticky flag.
  assign sum      = {1'b0, acc_out} + {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){1'b0}}, product};
  assign transfer = (state == ACCUM) && in_valid;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid && (counter == COUNT_WIDTH'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out  <= '0;
      counter  <= '0;
      overflow <= 1'b0;
    end else if ((state == IDLE) && start) begin
      acc_out  <= '0;
      overflow <= 1'b0;
      counter  <= length;
    end else if (transfer) begin
      acc_out <= sum[ACC_WIDTH-1:0];
      counter <= counter - COUNT_WIDTH'(1);
      if (sum[ACC_WIDTH]) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator at 20- and 16-bit accumulator widths
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, out_ready;
  logic [3:0]  length;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, overflow, busy;
  logic [19:0] acc_out;
  logic        in_ready16, out_valid16, overflow16, busy16;
  logic [15:0] acc_out16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(20), .COUNT_WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .busy(busy)
  );

  mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .COUNT_WIDTH(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .acc_out(acc_out16), .out_valid(out_valid16), .out_ready(out_ready),
    .overflow(overflow16), .busy(busy16)
  );

  typedef struct packed {
    logic [3:0]       len;
    logic [14:0][7:0] av;
    logic [14:0][7:0] bv;
    logic [14:0][1:0] gap;
    logic [2:0]       hold;
    logic [19:0]      exp20;
    logic             ov20;
    logic [15:0]      exp16;
    logic             ov16;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the true (unbounded) sum of products; wrap and overflow follow from it directly.
  task automatic chk_model(input string tag, input longint total);
    chk({tag, " acc20"}, 64'(acc_out), 64'(total % (64'd1 << 20)));
    chk({tag, " ovf20"}, 64'(overflow), 64'(total >= (64'd1 << 20)));
    chk({tag, " acc16"}, 64'(acc_out16), 64'(total % (64'd1 << 16)));
    chk({tag, " ovf16"}, 64'(overflow16), 64'(total >= (64'd1 << 16)));
  endtask

  task automatic chk_flags(input string tag, input logic e_busy, input logic e_ir, input logic e_ov);
    chk({tag, " busy"}, 64'(busy), 64'(e_busy));
    chk({tag, " busy16"}, 64'(busy16), 64'(e_busy));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(e_ir));
    chk({tag, " in_ready16"}, 64'(in_ready16), 64'(e_ir));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(e_ov));
    chk({tag, " out_valid16"}, 64'(out_valid16), 64'(e_ov));
  endtask

  // Entered just after a falling edge with the DUTs idle; returns just after a falling edge, idle.
  task automatic run_job(input logic [3:0] len, input logic [14:0][7:0] av,
                         input logic [14:0][7:0] bv, input logic [14:0][1:0] gap,
                         input int hold);
    longint total = 0;
    start = 1'b1; length = len; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk_model("job start", 0);
    chk_flags("job start", 1'b1, len != 0, len == 0);
    for (int i = 0; i < int'(len); i++) begin
      for (int g = 0; g < int'(gap[i]); g++) begin
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
        @(negedge clk);
        chk_model("gap", total);
        chk_flags("gap", 1'b1, 1'b1, 1'b0);
      end
      in_valid = 1'b1; a = av[i]; b = bv[i];
      total += longint'(av[i]) * longint'(bv[i]);
      @(negedge clk);
      chk_model("transfer", total);
      chk_flags("transfer", 1'b1, i != int'(len) - 1, i == int'(len) - 1);
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk_model("done hold", total);
      chk_flags("done hold", 1'b1, 1'b0, 1'b1);
    end
    start = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0; a = 8'($urandom); b = 8'($urandom);
    chk_model("exit", total);
    chk_flags("exit", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_model("idle keep", total);
    chk_flags("idle keep", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [14:0][7:0] rav, rbv;
    logic [14:0][1:0] rgap;

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    vecs[0].len = 4'd3;  vecs[0].exp20 = 20'd33; vecs[0].exp16 = 16'd33;
    vecs[0].av[0] = 8'd2; vecs[0].bv[0] = 8'd3;
    vecs[0].av[1] = 8'd4; vecs[0].bv[1] = 8'd5;
    vecs[0].av[2] = 8'd1; vecs[0].bv[2] = 8'd7;
    vecs[1].len = 4'd2;  vecs[1].exp20 = 20'd130; vecs[1].exp16 = 16'd130;
    vecs[1].av[0] = 8'd10; vecs[1].bv[0] = 8'd10;
    vecs[1].av[1] = 8'd5;  vecs[1].bv[1] = 8'd6; vecs[1].gap[1] = 2'd2;
    vecs[2].len = 4'd0;  vecs[2].hold = 3'd4;
    vecs[3].len = 4'd15; vecs[3].exp20 = 20'd975375; vecs[3].exp16 = 16'd57871; vecs[3].ov16 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      vecs[3].av[i] = 8'd255; vecs[3].bv[i] = 8'd255;
    end
    vecs[4].len = 4'd2;  vecs[4].exp20 = 20'd65026; vecs[4].exp16 = 16'd65026;
    vecs[4].av[0] = 8'd255; vecs[4].bv[0] = 8'd255;
    vecs[4].av[1] = 8'd1;   vecs[4].bv[1] = 8'd1;
    vecs[5].len = 4'd2;  vecs[5].exp20 = 20'd130050; vecs[5].exp16 = 16'd64514; vecs[5].ov16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vecs[5].av[i] = 8'd255; vecs[5].bv[i] = 8'd255;
    end

    rst_n = 1'b0; start = 1'b0; length = '0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    #2;
    chk_model("reset", 0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].len, vecs[i].av, vecs[i].bv, vecs[i].gap, int'(vecs[i].hold));
      chk("table acc20", 64'(acc_out), 64'(vecs[i].exp20));
      chk("table ovf20", 64'(overflow), 64'(vecs[i].ov20));
      chk("table acc16", 64'(acc_out16), 64'(vecs[i].exp16));
      chk("table ovf16", 64'(overflow16), 64'(vecs[i].ov16));
    end

    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 15; i++) begin
        rav[i]  = 8'($urandom);
        rbv[i]  = 8'($urandom);
        rgap[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      end
      run_job(4'($urandom_range(0, 15)), rav, rbv, rgap, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset between edges in the middle of a job.
    start = 1'b1; length = 4'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a = 8'd9; b = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    chk_model("pre-reset", 81);
    #2 rst_n = 1'b0;
    #1;
    chk_model("async reset", 0);
    chk_flags("async reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(4'd1, rav, rbv, '0, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk_flags("post reset idle", 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
